multi_crop_stream: RTL
======================

// Module: multi_crop_stream
// PURPOSE
//  Streaming image cropper: consumes one raster-order frame (IN_ROWS x IN_COLS pixels, one per beat)
//  and emits NUM_CROPS independent OUT_ROWS x OUT_COLS windows, one per output stream, in a single pass.
//  Each window origin is runtime-programmable and latched at ap_start. Sits between the pixel source and
//  the per-crop inference cores, with the ap_start/ap_done/ap_idle/ap_ready block-level control protocol.
// PARAMETERS
//  FP_TOTAL   16   pixel word width (bits)
//  IN_ROWS    100  input frame rows
//  IN_COLS    160  input frame columns
//  OUT_ROWS   48   crop rows (<= IN_ROWS)
//  OUT_COLS   48   crop columns (<= IN_COLS)
//  NUM_CROPS  2    number of crop windows / output streams (>= 1)
// PORTS
//  ap_clk        in   1                        clock
//  ap_rst_n      in   1                        reset, asynchronous, active-low
//  ap_start      in   1                        start one frame; sampled in IDLE only
//  ap_done       out  1                        1-cycle pulse when frame consumed and all crops drained
//  ap_idle       out  1                        high in IDLE
//  ap_ready      out  1                        1-cycle pulse when the last input pixel is accepted
//  crop_y        in   NUM_CROPS*$clog2(IN_ROWS) row origin of crop c at [c*RW +: RW]
//  crop_x        in   NUM_CROPS*$clog2(IN_COLS) col origin of crop c at [c*CW +: CW]
//  s_tdata       in   FP_TOTAL                  input pixel
//  s_tvalid      in   1                         input pixel valid
//  s_tready      out  1                         block accepts input pixel
//  m_tdata       out  NUM_CROPS*FP_TOTAL        crop c pixel at [c*FP_TOTAL +: FP_TOTAL]
//  m_tvalid      out  NUM_CROPS                 per-crop valid
//  m_tready      in   NUM_CROPS                 per-crop ready
// BEHAVIOUR
//  Reset (async, any state): IDLE; s_tready=0, m_tvalid=0, m_tdata=0, ap_done=0, ap_ready=0, ap_idle=1; counters 0.
//  FSM: IDLE -(ap_start)-> RUN -(last pixel accepted)-> FLUSH -(all m_tvalid==0)-> DONE -> IDLE (DONE is 1 cycle).
//  ap_start in RUN/FLUSH/DONE ignored. On IDLE->RUN, origins latched; y>IN_ROWS-OUT_ROWS clamps to
//   IN_ROWS-OUT_ROWS, x>IN_COLS-OUT_COLS clamps to IN_COLS-OUT_COLS (per crop, independently).
//  Row/col counters track raster position of the next input pixel; col wraps at IN_COLS-1, incrementing row.
//  in_c = (row in [y_c, y_c+OUT_ROWS-1]) && (col in [x_c, x_c+OUT_COLS-1]).
//  Each crop has one output register (valid bit + data). Slot c "free" = !m_tvalid[c] || m_tready[c].
//  s_tready = (state==RUN) && AND over c of (!in_c || free_c). Combinational from m_tready; no s_tvalid path.
//  Accept (s_tvalid&&s_tready): every crop with in_c loads s_tdata, sets m_tvalid[c]; others drain normally.
//  Simultaneous drain and load on a slot: register reloads, m_tvalid stays 1, no bubble; full throughput 1 px/cycle.
//  Pixels outside all crops are accepted and discarded whenever RUN (still gated by the term above = 1).
//  Latency: input accept -> m_tvalid high next cycle. m_tdata holds stable while m_tvalid && !m_tready.
//  ap_ready pulses in the cycle after the IN_ROWS*IN_COLS-th accept; ap_done pulses in DONE.
//  Overlapping crops legal: one pixel is loaded into several slots in the same cycle.
//  Reset mid-frame: all partial outputs discarded; next frame after ap_start is complete and exact.
// CONFIGURATION
//  CROP_TLAST_EN defined: adds port m_tlast out NUM_CROPS; m_tlast[c]=1 with the crop's final pixel
//   (row y_c+OUT_ROWS-1, col x_c+OUT_COLS-1), else 0; reset 0; held with m_tdata.
//  Not defined: no m_tlast port; behaviour otherwise identical.
// TESTING  (bench params IN 8x10, OUT 3x4, NUM_CROPS=2, FP_TOTAL=16; pixel value = r*10+c)
//  1 origins c0=(0,0), c1=(5,6), all ready=1 -> c0 emits 0,1,2,3,10..13,20..23; c1 emits 56..59,66..69,76..79;
//    ap_ready pulses once after 80th accept, ap_done pulses once, ap_idle returns 1.
//  2 origin c1=(7,9) -> clamped to (5,6): identical c1 sequence to scenario 1.
//  3 m_tready[1]=0 whole frame, c1=(0,0) -> s_tready drops at pixel 1 (c1 slot full), c1 holds 0;
//    release -> 12 words each, none lost/duplicated, FLUSH until both drain.
//  4 overlap c0=c1=(2,3), s_tvalid and m_tready random 50% for 5 frames -> both streams exactly 23..26,33..36,43..46.
//  5 ap_rst_n low after 30 accepts -> same cycle m_tvalid=0, ap_idle=1; next frame of scenario 1 exact.
//  6 CROP_TLAST_EN, scenario 1 -> m_tlast[0] only with 23, m_tlast[1] only with 79; build without macro compiles.

Source files
------------

// File: rtl/multi_crop_stream_if.sv
// Pixel stream bundle: LANES parallel data/valid/ready streams packed side by side.
// The tlast member exists only when CROP_TLAST_EN is defined.
interface multi_crop_stream_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1
);
  logic [LANES*DATA_W-1:0] tdata;
  logic [LANES-1:0]        tvalid;
  logic [LANES-1:0]        tready;
`ifdef CROP_TLAST_EN
  logic [LANES-1:0]        tlast;
  modport master (output tdata, tvalid, tlast, input tready);
`else
  modport master (output tdata, tvalid, input tready);
`endif
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/multi_crop_stream.sv
// Single-pass raster cropper: one input frame fans out into NUM_CROPS windowed output streams.
// Optional macro CROP_TLAST_EN adds a per-crop tlast marking each window's final pixel.

module multi_crop_stream_lane #(
  parameter int FP_TOTAL = 16,
  parameter int IN_ROWS  = 100,
  parameter int IN_COLS  = 160,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int RW       = 7,
  parameter int CW       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RW-1:0]       y_in,
  input  logic [CW-1:0]       x_in,
  input  logic [RW-1:0]       row,
  input  logic [CW-1:0]       col,
  input  logic                accept,
  input  logic [FP_TOTAL-1:0] din,
  input  logic                tready,
  output logic                in_win,
  output logic                free,
  output logic                tvalid,
`ifdef CROP_TLAST_EN
  output logic                tlast,
`endif
  output logic [FP_TOTAL-1:0] tdata
);
  localparam int Y_MAX = IN_ROWS - OUT_ROWS;
  localparam int X_MAX = IN_COLS - OUT_COLS;

  logic [RW-1:0] y0;
  logic [CW-1:0] x0;

  // Origins are clamped once at latch time so the window never runs off the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0 <= '0;
      x0 <= '0;
    end else if (start) begin
      y0 <= (int'(y_in) > Y_MAX) ? RW'(Y_MAX) : y_in;
      x0 <= (int'(x_in) > X_MAX) ? CW'(X_MAX) : x_in;
    end
  end

  always_comb begin
    in_win = (int'(row) >= int'(y0)) && (int'(row) < int'(y0) + OUT_ROWS) &&
             (int'(col) >= int'(x0)) && (int'(col) < int'(x0) + OUT_COLS);
  end

  assign free = !tvalid || tready;

`ifdef CROP_TLAST_EN
  logic last_px;
  assign last_px = (int'(row) == int'(y0) + OUT_ROWS - 1) &&
                   (int'(col) == int'(x0) + OUT_COLS - 1);
`endif

  // Load wins over drain, so a slot being emptied and refilled in one cycle stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
`ifdef CROP_TLAST_EN
      tlast  <= 1'b0;
`endif
    end else if (accept && in_win) begin
      tvalid <= 1'b1;
      tdata  <= din;
`ifdef CROP_TLAST_EN
      tlast  <= last_px;
`endif
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end
endmodule

module multi_crop_stream #(
  parameter int FP_TOTAL  = 16,
  parameter int IN_ROWS   = 100,
  parameter int IN_COLS   = 160,
  parameter int OUT_ROWS  = 48,
  parameter int OUT_COLS  = 48,
  parameter int NUM_CROPS = 2,
  localparam int RW = $clog2(IN_ROWS),
  localparam int CW = $clog2(IN_COLS)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [NUM_CROPS*RW-1:0] crop_y,
  input  logic [NUM_CROPS*CW-1:0] crop_x,
  multi_crop_stream_if.slave    s_axis,
  multi_crop_stream_if.master   m_axis
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          start, accept;

  logic [NUM_CROPS-1:0]               in_win, free, lane_vld;
  logic [NUM_CROPS-1:0][FP_TOTAL-1:0] lane_data;

  assign start  = (state == S_IDLE) && ap_start;
  // Stall only when some crop wants this pixel and its slot cannot take it.
  assign s_axis.tready = (state == S_RUN) && (&(~in_win | free));
  assign accept = s_axis.tvalid && s_axis.tready;

  assign m_axis.tvalid = lane_vld;
  assign m_axis.tdata  = lane_data;

`ifdef CROP_TLAST_EN
  logic [NUM_CROPS-1:0] lane_last;
  assign m_axis.tlast = lane_last;
`endif

  for (genvar c = 0; c < NUM_CROPS; c++) begin : g_lane
    multi_crop_stream_lane #(
      .FP_TOTAL(FP_TOTAL), .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS),
      .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS), .RW(RW), .CW(CW)
    ) u_lane (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .start  (start),
      .y_in   (crop_y[c*RW +: RW]),
      .x_in   (crop_x[c*CW +: CW]),
      .row    (row),
      .col    (col),
      .accept (accept),
      .din    (s_axis.tdata),
      .tready (m_axis.tready[c]),
      .in_win (in_win[c]),
      .free   (free[c]),
      .tvalid (lane_vld[c]),
`ifdef CROP_TLAST_EN
      .tlast  (lane_last[c]),
`endif
      .tdata  (lane_data[c])
    );
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      ap_ready <= 1'b0;
    end else begin
      ap_ready <= 1'b0;
      case (state)
        S_IDLE: if (ap_start) begin
          state <= S_RUN;
          row   <= '0;
          col   <= '0;
        end
        S_RUN: if (accept) begin
          if (col == CW'(IN_COLS - 1)) begin
            col <= '0;
            if (row == RW'(IN_ROWS - 1)) begin
              row      <= '0;
              state    <= S_FLUSH;
              ap_ready <= 1'b1;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        S_FLUSH: if (lane_vld == '0) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ap_done = (state == S_DONE);
  assign ap_idle = (state == S_IDLE);
endmodule
